kf_frame_sequencer: RTL
=======================

Name: kf_frame_sequencer

Overview:
- Upstream frame sequencer for the 2-state Kalman filter core.
- Buffers incoming measurement pairs (z00, z10) in a small FIFO and launches one filter frame per measurement with a single-cycle start pulse.
- Holds the frame's measurements and previous state stable for the whole frame, then feeds the posterior state back as next frame's x_prev.
- Presents each frame's result on a valid/ready output stream with a sequence number, and runs a watchdog on the core's done.

Parameters:
N, 16, fixed-point word width (matches core).
DEPTH, 4, measurement FIFO entries; power of two, >=2.
SEQ_W, 8, width of frame sequence counter.
TIMEOUT, 40, max cycles from kf_start to kf_done before error.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
s_valid  in  1  measurement pair valid
s_ready  out  1  FIFO not full
s_z00, s_z10  in  N each  signed measurement pair
init_load  in  1  load initial state (IDLE only)
init_x00, init_x10  in  N each  signed initial state
kf_start  out  1  one-cycle frame start to core
kf_z00_meas, kf_z10_meas  out  N each  held measurements
kf_x00_prev, kf_x10_prev  out  N each  held previous state
kf_done  in  1  core frame-done pulse
kf_x00_post, kf_x10_post  in  N each  core posterior state, valid while kf_done=1
m_valid  out  1  result valid
m_ready  in  1  result accepted
m_x00, m_x10  out  N each  result posterior state
m_seq  out  SEQ_W  result frame number
busy  out  1  frame in flight (state != IDLE)
err  out  1  sticky watchdog error

Behaviour:
- Reset values: all outputs 0 (s_ready=1), state IDLE, FIFO empty, seq=0, x_prev=0, watchdog counter=0.
- FIFO: push when s_valid && s_ready. s_ready = !full, registered, with no combinational path from m_ready. Push into empty FIFO gives no bypass; the entry is visible to the FSM on the next cycle. Pop happens only in IDLE launch.
- FSM states: IDLE, BUSY, COOL.
- IDLE -> BUSY when FIFO non-empty && !init_load && (!m_valid || m_ready). On that edge:
  - pop head into kf_z*_meas registers
  - register kf_start=1 for exactly the next cycle
  - clear watchdog counter
- Latency: s_valid accepted at edge T with FIFO empty and FSM idle gives kf_start high in the cycle after edge T+1.
- BUSY:
  - watchdog increments each cycle.
  - On kf_done: capture kf_x*_post into kf_x*_prev and into m_x*; m_seq<=seq; seq<=seq+1 (wraps at 2^SEQ_W); m_valid<=1; go to COOL.
  - If watchdog reaches TIMEOUT without kf_done: err<=1 (sticky until reset); x_prev, seq and m_* unchanged; go to COOL.
- COOL: exactly one cycle, then IDLE. This guarantees the core has dropped its running flag before the next start, so the earliest re-launch is kf_start 3 cycles after kf_done.
- kf_z*_meas and kf_x*_prev never change while BUSY.
- kf_done outside BUSY is ignored.
- Output stream: m_valid clears on m_valid && m_ready. m_* are stable while m_valid && !m_ready. Launch gating ensures the result slot is free at every kf_done.
- init_load applies only in IDLE: x_prev<=init_x*, and launch is blocked that cycle. init_load in BUSY/COOL is ignored.
- Async reset mid-frame: drops kf_start/m_valid immediately, flushes the FIFO, and abandons the in-flight frame.
- Arithmetic: none on data; data paths are register transfers. The watchdog counter is sized to hold TIMEOUT.

Test Plan:
- Single frame: init_load x=(0x0100,0x0200); push z=(0x0150,0x0250); model core asserts done 34 cycles after start with post=(0x0120,0x0230) -> one kf_start pulse, held z/x_prev match, m_valid with m_x=(0x0120,0x0230), m_seq=0.
- Back-to-back: push 4 pairs in 4 cycles, m_ready=1 -> s_ready low after 4th push only if none popped; 4 starts, each exactly 3 cycles after prior done; frame k uses x_prev = post of frame k-1; m_seq 0..3.
- Back-pressure: m_ready=0 after first result, FIFO holds 2 -> no second kf_start until m_ready pulses; m_x held stable; start follows 1 cycle after handshake.
- Watchdog: core never asserts done -> err=1 at TIMEOUT=40 cycles after start; no m_valid; x_prev unchanged; next frame still launches.
- FIFO full: push DEPTH=4 entries while BUSY -> s_ready=0, 5th s_valid not accepted; after the pop, s_ready returns to 1.
- Reset mid-frame: assert rst_n=0 at cycle 15 of BUSY -> all outputs 0, s_ready=1, seq=0; a fresh push after release launches normally with m_seq=0.

Source files
------------

// File: rtl/kf_frame_sequencer_if.sv
// kf_frame_sequencer_if
// Groups every non-clock signal of the Kalman frame sequencer.
//   s_*    : measurement pair stream into the sequencer (valid/ready)
//   init_* : initial state load, honoured only while the sequencer is idle
//   kf_*   : frame handshake with the 2-state Kalman core
//   m_*    : result stream out of the sequencer (valid/ready) with seq number
//   busy   : a frame is in flight
//   err    : sticky watchdog error
// Modports: slave = the sequencer, master = its environment.
interface kf_frame_sequencer_if #(
  parameter int N     = 16,
  parameter int SEQ_W = 8
);
  logic                s_valid;
  logic                s_ready;
  logic signed [N-1:0] s_z00;
  logic signed [N-1:0] s_z10;

  logic                init_load;
  logic signed [N-1:0] init_x00;
  logic signed [N-1:0] init_x10;

  logic                kf_start;
  logic signed [N-1:0] kf_z00_meas;
  logic signed [N-1:0] kf_z10_meas;
  logic signed [N-1:0] kf_x00_prev;
  logic signed [N-1:0] kf_x10_prev;
  logic                kf_done;
  logic signed [N-1:0] kf_x00_post;
  logic signed [N-1:0] kf_x10_post;

  logic                m_valid;
  logic                m_ready;
  logic signed [N-1:0] m_x00;
  logic signed [N-1:0] m_x10;
  logic [SEQ_W-1:0]    m_seq;

  logic                busy;
  logic                err;

  modport slave (
    input  s_valid, s_z00, s_z10,
    output s_ready,
    input  init_load, init_x00, init_x10,
    output kf_start, kf_z00_meas, kf_z10_meas, kf_x00_prev, kf_x10_prev,
    input  kf_done, kf_x00_post, kf_x10_post,
    output m_valid, m_x00, m_x10, m_seq,
    input  m_ready,
    output busy, err
  );

  modport master (
    output s_valid, s_z00, s_z10,
    input  s_ready,
    output init_load, init_x00, init_x10,
    input  kf_start, kf_z00_meas, kf_z10_meas, kf_x00_prev, kf_x10_prev,
    output kf_done, kf_x00_post, kf_x10_post,
    input  m_valid, m_x00, m_x10, m_seq,
    output m_ready,
    input  busy, err
  );
endinterface

// File: rtl/kf_frame_sequencer.sv
// kf_frame_sequencer
// Upstream frame sequencer for the 2-state Kalman filter core. Measurement
// pairs are buffered in a small FIFO; each one launches a filter frame with a
// one-cycle kf_start. Measurements and previous state are held for the whole
// frame, the posterior is fed back as the next frame's previous state and is
// also presented on the result stream with a frame sequence number.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : kf_frame_sequencer_if.slave (s_*, init_*, kf_*, m_*, busy, err)
module kf_frame_sequencer #(
  parameter int N       = 16,
  parameter int DEPTH   = 4,
  parameter int SEQ_W   = 8,
  parameter int TIMEOUT = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  kf_frame_sequencer_if.slave bus
);

  localparam int               AW         = $clog2(DEPTH);
  localparam int               WD_W       = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]      FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic signed [N-1:0] fifo_z00 [DEPTH];
  logic signed [N-1:0] fifo_z10 [DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr, fifo_count, fifo_count_next;
  logic                fifo_empty, push, pop;
  logic                s_ready_q;

  logic                launch, done_take, timeout_hit;
  logic [WD_W-1:0]     wd_cnt;
  logic [SEQ_W-1:0]    seq;
  logic                kf_start_q;
  logic signed [N-1:0] z00_q, z10_q, x00_prev_q, x10_prev_q;
  logic signed [N-1:0] m_x00_q, m_x10_q;
  logic [SEQ_W-1:0]    m_seq_q;
  logic                m_valid_q, err_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign push            = bus.s_valid && s_ready_q;
  assign pop             = launch;
  assign fifo_count      = wr_ptr - rd_ptr;
  assign fifo_empty      = (fifo_count == '0);
  assign fifo_count_next = fifo_count + (AW + 1)'(push) - (AW + 1)'(pop);

  // FIFO storage needs no reset: flushing is done by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_z00[wr_ptr[AW-1:0]] <= bus.s_z00;
      fifo_z10[wr_ptr[AW-1:0]] <= bus.s_z10;
    end
  end

  // s_ready is registered from the post-edge occupancy, so it never sees
  // m_ready combinationally even though a pop depends on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      s_ready_q <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW + 1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW + 1)'(1);
      end
      s_ready_q <= (fifo_count_next != FULL_COUNT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Launch waits for a free result slot so every kf_done can be captured.
  // A done on the final watchdog cycle still counts as a good frame.
  always_comb begin
    state_d     = state_q;
    launch      = 1'b0;
    done_take   = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !bus.init_load && (!m_valid_q || bus.m_ready)) begin
          launch  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.kf_done) begin
          done_take = 1'b1;
          state_d   = COOL;
        end else if (wd_cnt == WD_LAST) begin
          timeout_hit = 1'b1;
          state_d     = COOL;
        end
      end
      COOL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame datapath: held measurements, previous state, watchdog and sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kf_start_q <= 1'b0;
      z00_q      <= '0;
      z10_q      <= '0;
      x00_prev_q <= '0;
      x10_prev_q <= '0;
      wd_cnt     <= '0;
      seq        <= '0;
      err_q      <= 1'b0;
    end else begin
      kf_start_q <= launch;
      if (launch) begin
        z00_q  <= fifo_z00[rd_ptr[AW-1:0]];
        z10_q  <= fifo_z10[rd_ptr[AW-1:0]];
        wd_cnt <= '0;
      end else if (state_q == BUSY) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (state_q == IDLE && bus.init_load) begin
        x00_prev_q <= bus.init_x00;
        x10_prev_q <= bus.init_x10;
      end
      if (done_take) begin
        x00_prev_q <= bus.kf_x00_post;
        x10_prev_q <= bus.kf_x10_post;
        seq        <= seq + SEQ_W'(1);
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  // Result stream: a new result always lands in a free slot (see launch).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_x00_q   <= '0;
      m_x10_q   <= '0;
      m_seq_q   <= '0;
    end else begin
      if (done_take) begin
        m_valid_q <= 1'b1;
        m_x00_q   <= bus.kf_x00_post;
        m_x10_q   <= bus.kf_x10_post;
        m_seq_q   <= seq;
      end else if (m_valid_q && bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign bus.s_ready     = s_ready_q;
  assign bus.kf_start    = kf_start_q;
  assign bus.kf_z00_meas = z00_q;
  assign bus.kf_z10_meas = z10_q;
  assign bus.kf_x00_prev = x00_prev_q;
  assign bus.kf_x10_prev = x10_prev_q;
  assign bus.m_valid     = m_valid_q;
  assign bus.m_x00       = m_x00_q;
  assign bus.m_x10       = m_x10_q;
  assign bus.m_seq       = m_seq_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.err         = err_q;

endmodule
